// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: shares one FIR MAC datapath between N_CH channels.
// Pending samples are granted round-robin, the selected bank is loaded, TAPS
// accumulate cycles are sequenced, and the result is handed downstream with
// its channel tag under a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RESET  | datapath banks being cleared after reset
// IDLE   | no sample in flight, waiting for any ch_valid
// LOAD   | accept sample into sel_ch delay line, clear accumulator
// CALC   | TAPS accumulate cycles, coef_addr walks 0..TAPS-1
// DONE   | capture accumulator into the output register
// OUT    | result presented, waiting for out_ready
module fir_channel_scheduler #(
  parameter int N_CH  = 4,
  parameter int TAPS  = 16,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             cu_rst_n,
  input  logic [N_CH-1:0]  ch_valid,
  output logic [N_CH-1:0]  ch_ready,
  input  logic             out_ready,
  output logic             dp_rst,
  output logic [CH_W-1:0]  sel_ch,
  output logic             shift_enb,
  output logic             acc_clr,
  output logic             count_enb,
  output logic [TAP_W-1:0] coef_addr,
  output logic             register_enb,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CALC  = 3'd3,
    ST_DONE  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_ch;
  logic            grant_hit;
  logic            take_grant;
  logic            coef_last;

  // Channel index a + b, wrapped into 0..N_CH-1 (N_CH need not be a power of two).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int unsigned b);
    int unsigned s;
    s = int'(a) + b;
    if (s >= 32'(N_CH)) s = s - 32'(N_CH);
    return CH_W'(s);
  endfunction

  // Round-robin pick: scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_hit = |ch_valid;
    grant_ch  = rr_ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_valid[wrap_add(rr_ptr, i)]) grant_ch = wrap_add(rr_ptr, i);
    end
  end

  assign take_grant = grant_hit && ((state == ST_IDLE) || ((state == ST_OUT) && out_ready));
  assign coef_last  = (coef_addr == TAP_W'(TAPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!cu_rst_n) state <= ST_RESET;
    else           state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_IDLE;
      ST_IDLE:  if (grant_hit) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_CALC;
      ST_CALC:  if (coef_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = grant_hit ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // Moore strobes, decoded from the state only.
  always_comb begin
    ch_ready     = '0;
    dp_rst       = 1'b0;
    shift_enb    = 1'b0;
    acc_clr      = 1'b0;
    count_enb    = 1'b0;
    register_enb = 1'b0;
    out_valid    = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_RESET: dp_rst = 1'b1;
      ST_LOAD: begin
        ch_ready[sel_ch] = 1'b1;
        shift_enb        = 1'b1;
        acc_clr          = 1'b1;
      end
      ST_CALC:  count_enb    = 1'b1;
      ST_DONE:  register_enb = 1'b1;
      ST_OUT:   out_valid    = 1'b1;
      default:  ;
    endcase
  end

  // Grant pointer, bank select, tap address and result tag registers.
  always_ff @(posedge clk) begin
    if (!cu_rst_n) begin
      rr_ptr    <= '0;
      sel_ch    <= '0;
      out_ch    <= '0;
      coef_addr <= '0;
    end else begin
      if (take_grant) begin
        sel_ch <= grant_ch;
        rr_ptr <= wrap_add(grant_ch, 1);
      end
      case (state)
        ST_LOAD: coef_addr <= '0;
        ST_CALC: coef_addr <= coef_last ? '0 : coef_addr + 1'b1;
        ST_DONE: out_ch    <= sel_ch;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler with N_CH=4, TAPS=4. A timeline model
// (phase counter per served sample) predicts every output on every cycle;
// directed scenarios add literal expectations on grant order and timing.
module tb_fir_channel_scheduler;
  localparam int N_CH  = 4;
  localparam int TAPS  = 4;
  localparam int CH_W  = 2;
  localparam int TAP_W = 2;

  // Phase numbering of the model: one value per cycle of a served sample.
  localparam int P_RST   = 0;
  localparam int P_IDLE  = 1;
  localparam int P_LOAD  = 2;
  localparam int P_CALC0 = 3;
  localparam int P_DONE  = TAPS + 3;
  localparam int P_OUT   = TAPS + 4;

  logic             clk;
  logic             cu_rst_n;
  logic [N_CH-1:0]  ch_valid;
  logic [N_CH-1:0]  ch_ready;
  logic             out_ready;
  logic             dp_rst;
  logic [CH_W-1:0]  sel_ch;
  logic             shift_enb;
  logic             acc_clr;
  logic             count_enb;
  logic [TAP_W-1:0] coef_addr;
  logic             register_enb;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic             busy;

  fir_channel_scheduler #(.N_CH(N_CH), .TAPS(TAPS)) dut (
    .clk(clk), .cu_rst_n(cu_rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .out_ready(out_ready), .dp_rst(dp_rst), .sel_ch(sel_ch), .shift_enb(shift_enb),
    .acc_clr(acc_clr), .count_enb(count_enb), .coef_addr(coef_addr),
    .register_enb(register_enb), .out_valid(out_valid), .out_ch(out_ch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    int phase;
    int rr;
    int sel;
    int och;
  } mdl_t;

  function automatic mdl_t mdl_grant(input mdl_t s, input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) begin
      int c = (s.rr + i) % N_CH;
      if (v[c]) begin
        s.sel   = c;
        s.rr    = (c + 1) % N_CH;
        s.phase = P_LOAD;
        return s;
      end
    end
    s.phase = P_IDLE;
    return s;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic rst_n,
                                    input logic [N_CH-1:0] v, input logic ordy);
    if (!rst_n) begin
      s.phase = P_RST; s.rr = 0; s.sel = 0; s.och = 0;
      return s;
    end
    if (s.phase == P_RST)       s.phase = P_IDLE;
    else if (s.phase == P_IDLE) s = mdl_grant(s, v);
    else if (s.phase == P_DONE) begin s.och = s.sel; s.phase = P_OUT; end
    else if (s.phase == P_OUT)  begin if (ordy) s = mdl_grant(s, v); end
    else                        s.phase = s.phase + 1;
    return s;
  endfunction

  mdl_t m;
  bit   m_known = 1'b0;

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    m <= mdl_step(m, cu_rst_n, ch_valid, out_ready);
    if (!cu_rst_n) m_known <= 1'b1;
  end

  // ---------------- monitor / compare ----------------
  int              cyc = 0;
  int              n_calc = 0;
  bit              ov_prev = 1'b0;
  logic [N_CH-1:0] rdy_seen = '0;
  int              g_cyc[$];
  int              g_ch[$];
  int              ov_cyc[$];
  int              ov_ch[$];

  function automatic int oh_idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int in_calc(input int ph);
    return (ph >= P_CALC0 && ph < P_DONE) ? 1 : 0;
  endfunction

  // Every-cycle comparison against the model, plus event logging.
  always @(negedge clk) begin
    if (m_known) begin
      chk("dp_rst",       dp_rst,       (m.phase == P_RST)  ? 1 : 0);
      chk("busy",         busy,         (m.phase != P_IDLE) ? 1 : 0);
      chk("ch_ready",     ch_ready,     (m.phase == P_LOAD) ? (1 << m.sel) : 0);
      chk("shift_enb",    shift_enb,    (m.phase == P_LOAD) ? 1 : 0);
      chk("acc_clr",      acc_clr,      (m.phase == P_LOAD) ? 1 : 0);
      chk("count_enb",    count_enb,    in_calc(m.phase));
      chk("coef_addr",    coef_addr,    in_calc(m.phase) ? m.phase - P_CALC0 : 0);
      chk("register_enb", register_enb, (m.phase == P_DONE) ? 1 : 0);
      chk("out_valid",    out_valid,    (m.phase == P_OUT)  ? 1 : 0);
      chk("out_ch",       out_ch,       m.och);
      chk("sel_ch",       sel_ch,       m.sel);
    end
    if (ch_ready != '0) begin
      g_cyc.push_back(cyc);
      g_ch.push_back(oh_idx(ch_ready));
    end
    if (out_valid && !ov_prev) begin
      ov_cyc.push_back(cyc);
      ov_ch.push_back(int'(out_ch));
    end
    if (count_enb) n_calc <= n_calc + 1;
    ov_prev  <= out_valid;
    rdy_seen <= ch_ready;
    cyc      <= cyc + 1;
  end

  // ---------------- stimulus ----------------
  bit auto_drop = 1'b1;

  // Advance one cycle; a requester drops ch_valid once its ch_ready was seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) ch_valid = ch_valid & ~rdy_seen;
  endtask

  task automatic do_reset();
    cu_rst_n = 1'b0;
    tick();
    tick();
    cu_rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    chk(name, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gbase, obase, cbase;
    cu_rst_n  = 1'b0;
    ch_valid  = '0;
    out_ready = 1'b1;

    // Reset held for 3 edges, then released.
    repeat (3) tick();
    cu_rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_dp_rst_hold", dp_rst, 1);
    chk("rst_busy", busy, 1);
    chk("rst_others_zero", {ch_ready, shift_enb, acc_clr, count_enb, coef_addr,
                            register_enb, out_valid, out_ch, sel_ch}, 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_dp_rst", dp_rst, 0);

    // Single request from ch2.
    gbase = g_ch.size(); obase = ov_cyc.size(); cbase = n_calc;
    ch_valid = 4'b0100;
    for (int i = 0; i < 30 && ov_cyc.size() == obase; i++) tick();
    chk("single_out_seen", ov_cyc.size() - obase, 1);
    chk("single_grants", g_ch.size() - gbase, 1);
    if (g_ch.size() > gbase && ov_cyc.size() > obase) begin
      chk("single_grant_ch", g_ch[gbase], 2);
      chk("single_load_to_out", ov_cyc[obase] - g_cyc[gbase], 6);
      chk("single_out_ch", ov_ch[obase], 2);
    end
    chk("single_calc_cycles", n_calc - cbase, 4);
    chk("single_req_dropped", ch_valid, 0);
    wait_idle("single_idle", 20);

    // Round-robin with all channels held.
    do_reset();
    gbase = g_ch.size();
    auto_drop = 1'b0;
    ch_valid  = 4'b1111;
    for (int i = 0; i < 60 && g_ch.size() < gbase + 5; i++) tick();
    ch_valid  = '0;
    auto_drop = 1'b1;
    chk("rr_grants", g_ch.size() - gbase, 5);
    if (g_ch.size() >= gbase + 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", g_ch[gbase + i], i % 4);
      for (int i = 1; i < 5; i++) chk("rr_spacing", g_cyc[gbase + i] - g_cyc[gbase + i - 1], 7);
    end
    wait_idle("rr_idle", 20);

    // Backpressure: 10 stalled cycles in OUT, then handshake with ch1 pending.
    out_ready = 1'b0;
    ch_valid  = 4'b0001;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("bp_reach_out", out_valid, 1);
    gbase = g_ch.size();
    ch_valid = ch_valid | 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid_hold", out_valid, 1);
      chk("bp_out_ch_hold", out_ch, 0);
    end
    chk("bp_no_grant", g_ch.size() - gbase, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_direct_load", ch_ready, 4'b0010);
    chk("bp_busy", busy, 1);
    wait_idle("bp_idle", 20);

    // Reset in the middle of CALC drops the sample and resets the pointer.
    obase = ov_cyc.size();
    ch_valid = 4'b0001;
    for (int i = 0; i < 20 && !(count_enb && coef_addr == 2); i++) tick();
    chk("mid_reach_coef2", coef_addr, 2);
    cu_rst_n = 1'b0;
    tick();
    chk("mid_count_enb", count_enb, 0);
    chk("mid_dp_rst", dp_rst, 1);
    tick();
    cu_rst_n = 1'b1;
    tick();
    chk("mid_idle", busy, 0);
    chk("mid_no_out", ov_cyc.size() - obase, 0);
    gbase = g_ch.size();
    ch_valid = 4'b1001;
    for (int i = 0; i < 5 && g_ch.size() == gbase; i++) tick();
    chk("mid_grants", g_ch.size() - gbase, 1);
    if (g_ch.size() > gbase) chk("mid_ch0_wins", g_ch[gbase], 0);
    wait_idle("mid_idle_after", 40);

    // Late arrival: ch3 raised while ch0 is in CALC.
    gbase = g_ch.size(); obase = ov_cyc.size();
    ch_valid = 4'b0001;
    for (int i = 0; i < 10 && !count_enb; i++) tick();
    chk("late_in_calc", count_enb, 1);
    ch_valid = ch_valid | 4'b1000;
    for (int i = 0; i < 30 && g_ch.size() < gbase + 2; i++) tick();
    chk("late_grants", g_ch.size() - gbase, 2);
    if (g_ch.size() >= gbase + 2 && ov_cyc.size() > obase) begin
      chk("late_first_ch0", g_ch[gbase], 0);
      chk("late_ch3_next", g_ch[gbase + 1], 3);
      chk("late_at_handshake", g_cyc[gbase + 1] - ov_cyc[obase], 1);
    end
    wait_idle("late_idle", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
